// File: rtl/photonic_link_arbiter.sv
// photonic_link_arbiter
//   Collects one packet per core in a single-entry slot and grants the shared
//   photonic waveguide round-robin. A LINK_LAT-cycle flight phase follows each
//   grant. Then the packet is broadcast on rx_pkt and the destination core's
//   rx_we is strobed. A packet whose destination does not exist is dropped
//   and reported with a single-cycle dest_err.
//
//   Optional macro PHOTONIC_ARB_BROADCAST_EN: when it is defined, an all-ones
//   destination id is a broadcast. It is delivered to every node except the
//   source and never raises dest_err.
//
//   Packet layout: {dest[ID_WIDTH], data[DATA_WIDTH], src[ID_WIDTH]}.

module photonic_link_arbiter #(
    parameter int NODES      = 4,
    parameter int ID_WIDTH   = 2,
    parameter int DATA_WIDTH = 32,
    parameter int LINK_LAT   = 2
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [NODES*(2*ID_WIDTH+DATA_WIDTH)-1:0]     tx_pkt,
    input  logic [NODES-1:0]                             tx_valid,
    output logic [NODES-1:0]                             tx_ready,
    output logic [2*ID_WIDTH+DATA_WIDTH-1:0]             rx_pkt,
    output logic [NODES-1:0]                             rx_we,
    output logic                                         busy,
    output logic                                         dest_err
);

    localparam int PKT_W = 2*ID_WIDTH + DATA_WIDTH;
    localparam int CNT_W = (LINK_LAT > 1) ? $clog2(LINK_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER    = 2'd1,
        DELIVER = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ID_WIDTH-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NODES-1:0]      full_q, full_d;
    logic [PKT_W-1:0]      slot_q [NODES];
    logic [PKT_W-1:0]      slot_d [NODES];
    logic [PKT_W-1:0]      rx_pkt_q, rx_pkt_d;
    logic [NODES-1:0]      rx_we_q, rx_we_d;
    logic                  dest_err_q, dest_err_d;

    logic                  found_s;
    logic [ID_WIDTH-1:0]   cand_s;
    logic [PKT_W-1:0]      sel_pkt_s;
    logic [ID_WIDTH-1:0]   dest_s;
`ifdef PHOTONIC_ARB_BROADCAST_EN
    logic [ID_WIDTH-1:0]   src_s;
`endif

    // Next-state logic: slot accepts, round-robin search, flight countdown, delivery decode
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        full_d     = full_q;
        slot_d     = slot_q;
        rx_pkt_d   = rx_pkt_q;
        rx_we_d    = '0;
        dest_err_d = 1'b0;
        found_s    = 1'b0;
        cand_s     = '0;
        sel_pkt_s  = slot_q[grant_q];
        dest_s     = sel_pkt_s[PKT_W-1 -: ID_WIDTH];
`ifdef PHOTONIC_ARB_BROADCAST_EN
        src_s      = sel_pkt_s[ID_WIDTH-1:0];
`endif

        // A slot is accepted only when it was empty at the start of the cycle.
        for (int i = 0; i < NODES; i++) begin
            if (tx_valid[i] && !full_q[i]) begin
                full_d[i] = 1'b1;
                slot_d[i] = tx_pkt[i*PKT_W +: PKT_W];
            end else begin
                full_d[i] = full_d[i];
            end
        end

        case (state_q)
            IDLE: begin
                // Search starts at ptr. Only the registered full bits are
                // eligible, so a packet accepted on the same edge waits.
                for (int k = 0; k < NODES; k++) begin
                    if (!found_s && full_q[(int'(ptr_q) + k) % NODES]) begin
                        found_s = 1'b1;
                        cand_s  = ID_WIDTH'((int'(ptr_q) + k) % NODES);
                    end else begin
                        found_s = found_s;
                    end
                end
                if (found_s) begin
                    grant_d = cand_s;
                    cnt_d   = CNT_W'(LINK_LAT - 1);
                    state_d = XFER;
                end else begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                if (cnt_q == '0) begin
                    // The outputs are loaded on the way into DELIVER, so the
                    // strobe lines up with the DELIVER cycle.
                    state_d  = DELIVER;
                    rx_pkt_d = sel_pkt_s;
`ifdef PHOTONIC_ARB_BROADCAST_EN
                    if (dest_s == {ID_WIDTH{1'b1}}) begin
                        for (int n = 0; n < NODES; n++) begin
                            rx_we_d[n] = (src_s != ID_WIDTH'(n));
                        end
                    end else if (int'(dest_s) < NODES) begin
`else
                    if (int'(dest_s) < NODES) begin
`endif
                        for (int n = 0; n < NODES; n++) begin
                            rx_we_d[n] = (dest_s == ID_WIDTH'(n));
                        end
                    end else begin
                        dest_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DELIVER: begin
                full_d[grant_q] = 1'b0;
                ptr_d           = ID_WIDTH'((int'(grant_q) + 1) % NODES);
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            cnt_q      <= '0;
            full_q     <= '0;
            rx_pkt_q   <= '0;
            rx_we_q    <= '0;
            dest_err_q <= 1'b0;
            for (int i = 0; i < NODES; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            full_q     <= full_d;
            rx_pkt_q   <= rx_pkt_d;
            rx_we_q    <= rx_we_d;
            dest_err_q <= dest_err_d;
            for (int i = 0; i < NODES; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign tx_ready = ~full_q;
    assign rx_pkt   = rx_pkt_q;
    assign rx_we    = rx_we_q;
    assign dest_err = dest_err_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_photonic_link_arbiter.sv
// Directed testbench for photonic_link_arbiter. It uses a 4-node instance
// and a 3-node instance, each with LINK_LAT=2. The expected values are
// worked out by hand from the block's cycle timing.
`timescale 1ns/1ps
module tb_photonic_link_arbiter;

    localparam int IDW = 2;
    localparam int DW  = 32;
    localparam int PW  = 2*IDW + DW;

    logic            clk = 1'b0;
    logic            rst;
    logic [4*PW-1:0] tx_pkt4;
    logic [3:0]      tx_valid4, tx_ready4, rx_we4;
    logic [PW-1:0]   rx_pkt4;
    logic            busy4, dest_err4;
    logic [3*PW-1:0] tx_pkt3;
    logic [2:0]      tx_valid3, tx_ready3, rx_we3;
    logic [PW-1:0]   rx_pkt3;
    logic            busy3, dest_err3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    photonic_link_arbiter #(.NODES(4), .ID_WIDTH(IDW), .DATA_WIDTH(DW), .LINK_LAT(2)) dut4 (
        .clk(clk), .rst(rst), .tx_pkt(tx_pkt4), .tx_valid(tx_valid4), .tx_ready(tx_ready4),
        .rx_pkt(rx_pkt4), .rx_we(rx_we4), .busy(busy4), .dest_err(dest_err4));

    photonic_link_arbiter #(.NODES(3), .ID_WIDTH(IDW), .DATA_WIDTH(DW), .LINK_LAT(2)) dut3 (
        .clk(clk), .rst(rst), .tx_pkt(tx_pkt3), .tx_valid(tx_valid3), .tx_ready(tx_ready3),
        .rx_pkt(rx_pkt3), .rx_we(rx_we3), .busy(busy3), .dest_err(dest_err3));

    function automatic logic [PW-1:0] mk(input logic [1:0] d, input logic [31:0] data, input logic [1:0] s);
        return {d, data, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tx_valid4 = '0;
        tx_valid3 = '0;
        tx_pkt4   = '0;
        tx_pkt3   = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (rx_we4 !== 4'b0000 || dest_err4 !== 1'b0 || busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl4: rx_we=%b dest_err=%b busy=%b, want 0000/0/0", rx_we4, dest_err4, busy4);
        end
        n_checks++;
        if (tx_ready4 !== 4'b1111 || rx_pkt4 !== '0) begin
            n_fail++;
            $display("FAIL reset_data4: tx_ready=%b rx_pkt=%h, want 1111/0", tx_ready4, rx_pkt4);
        end
        n_checks++;
        if (tx_ready3 !== 3'b111 || busy3 !== 1'b0 || rx_we3 !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_dut3: tx_ready=%b busy=%b rx_we=%b", tx_ready3, busy3, rx_we3);
        end
    endtask

    task automatic test_single();
        logic [PW-1:0] p;
        do_reset();
        p = mk(2'd2, 32'hDEADBEEF, 2'd1);
        tx_pkt4[1*PW +: PW] = p;
        tx_valid4[1] = 1'b1;
        tick();                       // E0: accept
        tx_valid4 = '0;
        n_checks++;
        if (tx_ready4 !== 4'b1101 || busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_accept: tx_ready=%b busy=%b, want 1101/0", tx_ready4, busy4);
        end
        tick();                       // E1
        n_checks++;
        if (busy4 !== 1'b1 || rx_we4 !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_xfer1: busy=%b rx_we=%b, want 1/0000", busy4, rx_we4);
        end
        tick();                       // E2
        n_checks++;
        if (rx_we4 !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_xfer2: rx_we=%b, want 0000", rx_we4);
        end
        tick();                       // E3: DELIVER
        n_checks++;
        if (rx_we4 !== 4'b0100 || rx_pkt4 !== p || dest_err4 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_deliver: rx_we=%b rx_pkt=%h dest_err=%b, want 0100/%h/0", rx_we4, rx_pkt4, dest_err4, p);
        end
        tick();                       // E4
        n_checks++;
        if (rx_we4 !== 4'b0000 || tx_ready4 !== 4'b1111 || busy4 !== 1'b0 || rx_pkt4 !== p) begin
            n_fail++;
            $display("FAIL single_after: rx_we=%b tx_ready=%b busy=%b rx_pkt=%h", rx_we4, tx_ready4, busy4, rx_pkt4);
        end
    endtask

    task automatic test_round_robin();
        int          nd;
        int          got_k    [8];
        logic [1:0]  got_src  [8];
        logic [31:0] got_data [8];
        logic [3:0]  got_we   [8];
        int          exp_k    [5] = '{3, 7, 11, 15, 19};
        logic [1:0]  exp_src  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [31:0] exp_data [5] = '{32'hA0A0_0000, 32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003, 32'hB0B0_0000};
        logic [3:0]  exp_we   [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0100};
        logic        pre;
        do_reset();
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            tx_pkt4[i*PW +: PW] = mk(2'((i + 1) % 4), 32'hA0A0_0000 + 32'(i), 2'(i));
        end
        tx_valid4 = 4'b1111;
        tick();                       // E0: all four accepted
        tx_valid4 = 4'b0001;
        tx_pkt4[0 +: PW] = mk(2'd2, 32'hB0B0_0000, 2'd0);
        for (int k = 1; k <= 22; k++) begin
            pre = tx_valid4[0] & tx_ready4[0];
            tick();
            if (pre) tx_valid4[0] = 1'b0;
            if (rx_we4 !== 4'b0000 && nd < 8) begin
                got_k[nd]    = k;
                got_src[nd]  = rx_pkt4[1:0];
                got_data[nd] = rx_pkt4[DW+IDW-1:IDW];
                got_we[nd]   = rx_we4;
                nd++;
            end
        end
        tx_valid4 = '0;
        n_checks++;
        if (nd !== 5) begin
            n_fail++;
            $display("FAIL rr_count: %0d deliveries, want 5", nd);
        end
        for (int j = 0; j < 5; j++) begin
            if (j < nd) begin
                n_checks++;
                if (got_k[j] !== exp_k[j] || got_src[j] !== exp_src[j] ||
                    got_data[j] !== exp_data[j] || got_we[j] !== exp_we[j]) begin
                    n_fail++;
                    $display("FAIL rr_delivery%0d: cycle=%0d src=%0d data=%h we=%b, want cycle=%0d src=%0d data=%h we=%b",
                             j, got_k[j], got_src[j], got_data[j], got_we[j], exp_k[j], exp_src[j], exp_data[j], exp_we[j]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] p1, p2;
        int n_acc, acc_k, n_p1, n_p2, p2_k;
        logic pre;
        do_reset();
        p1 = mk(2'd3, 32'h1111_2222, 2'd2);
        p2 = mk(2'd0, 32'h3333_4444, 2'd2);
        n_acc = 0; acc_k = -1; n_p1 = 0; n_p2 = 0; p2_k = -1;
        tx_pkt4[2*PW +: PW] = p1;
        tx_valid4[2] = 1'b1;
        tick();                       // E0: p1 accepted
        tx_pkt4[2*PW +: PW] = p2;     // valid held with the second packet
        for (int k = 1; k <= 14; k++) begin
            pre = tx_valid4[2] & tx_ready4[2];
            tick();
            if (pre) begin
                n_acc++;
                acc_k = k;
                tx_valid4[2] = 1'b0;
            end
            if (rx_we4 !== 4'b0000) begin
                if (rx_pkt4 === p1) n_p1++;
                if (rx_pkt4 === p2) begin
                    n_p2++;
                    p2_k = k;
                end
            end
        end
        tx_valid4 = '0;
        n_checks++;
        if (n_acc !== 1 || acc_k !== 5) begin
            n_fail++;
            $display("FAIL bp_accept: accepts=%0d at edge %0d, want 1 at edge 5", n_acc, acc_k);
        end
        n_checks++;
        if (n_p1 !== 1 || n_p2 !== 1 || p2_k !== 8) begin
            n_fail++;
            $display("FAIL bp_deliver: p1=%0d p2=%0d p2_cycle=%0d, want 1/1/8", n_p1, n_p2, p2_k);
        end
    endtask

    task automatic test_bad_dest();
        int n_err, err_k, n_we, we_k;
        logic [2:0] first_we;
        logic [PW-1:0] last_pkt;
        logic ready0_k4;
`ifdef PHOTONIC_ARB_BROADCAST_EN
        logic [2:0] exp_first_we = 3'b110;
        int         exp_n_err    = 0;
        int         exp_n_we     = 2;
`else
        logic [2:0] exp_first_we = 3'b100;
        int         exp_n_err    = 1;
        int         exp_n_we     = 1;
`endif
        do_reset();
        n_err = 0; err_k = -1; n_we = 0; we_k = -1; first_we = '0; last_pkt = '0; ready0_k4 = 1'b0;
        tx_pkt3[0*PW +: PW] = mk(2'd3, 32'hBAD0_0003, 2'd0);
        tx_pkt3[1*PW +: PW] = mk(2'd2, 32'h600D_0002, 2'd1);
        tx_valid3 = 3'b011;
        tick();                       // E0
        tx_valid3 = '0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (dest_err3 === 1'b1) begin
                n_err++;
                err_k = k;
                n_checks++;
                if (rx_we3 !== 3'b000) begin
                    n_fail++;
                    $display("FAIL bad_we_during_err: rx_we=%b, want 000", rx_we3);
                end
            end
            if (rx_we3 !== 3'b000) begin
                if (n_we == 0) first_we = rx_we3;
                n_we++;
                we_k = k;
                last_pkt = rx_pkt3;
            end
            if (k == 4) ready0_k4 = tx_ready3[0];
        end
        n_checks++;
        if (n_err !== exp_n_err || (exp_n_err == 1 && err_k !== 3)) begin
            n_fail++;
            $display("FAIL bad_dest_err: pulses=%0d last at %0d, want %0d at 3", n_err, err_k, exp_n_err);
        end
        n_checks++;
        if (n_we !== exp_n_we || first_we !== exp_first_we || we_k !== 7 ||
            last_pkt !== mk(2'd2, 32'h600D_0002, 2'd1)) begin
            n_fail++;
            $display("FAIL bad_dest_next: strobes=%0d first=%b last at %0d pkt=%h, want %0d/%b/7",
                     n_we, first_we, we_k, last_pkt, exp_n_we, exp_first_we);
        end
        n_checks++;
        if (ready0_k4 !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_dest_free: tx_ready[0]=%b at cycle 4, want 1", ready0_k4);
        end
    endtask

    task automatic test_reset_midflight();
        int n_we;
        do_reset();
        n_we = 0;
        tx_pkt4[0*PW +: PW] = mk(2'd1, 32'hCAFE_0000, 2'd0);
        tx_pkt4[1*PW +: PW] = mk(2'd0, 32'hCAFE_0001, 2'd1);
        tx_valid4 = 4'b0011;
        tick();                       // E0
        tx_valid4 = '0;
        tick();                       // E1: now in XFER
        n_checks++;
        if (busy4 !== 1'b1 || tx_ready4 !== 4'b1100) begin
            n_fail++;
            $display("FAIL midrst_pre: busy=%b tx_ready=%b, want 1/1100", busy4, tx_ready4);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (busy4 !== 1'b0 || tx_ready4 !== 4'b1111 || rx_we4 !== 4'b0000) begin
            n_fail++;
            $display("FAIL midrst_post: busy=%b tx_ready=%b rx_we=%b, want 0/1111/0000", busy4, tx_ready4, rx_we4);
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            if (rx_we4 !== 4'b0000 || busy4 !== 1'b0) n_we++;
        end
        n_checks++;
        if (n_we !== 0) begin
            n_fail++;
            $display("FAIL midrst_quiet: %0d cycles with activity, want 0", n_we);
        end
    endtask

    task automatic test_broadcast();
`ifdef PHOTONIC_ARB_BROADCAST_EN
        logic [3:0] exp_we = 4'b1110;
`else
        logic [3:0] exp_we = 4'b1000;
`endif
        do_reset();
        tx_pkt4[0*PW +: PW] = mk(2'd3, 32'h5555_AAAA, 2'd0);
        tx_valid4[0] = 1'b1;
        tick();                       // E0
        tx_valid4 = '0;
        tick();
        tick();
        tick();                       // E3: DELIVER
        n_checks++;
        if (rx_we4 !== exp_we || dest_err4 !== 1'b0 || rx_pkt4 !== mk(2'd3, 32'h5555_AAAA, 2'd0)) begin
            n_fail++;
            $display("FAIL broadcast: rx_we=%b dest_err=%b rx_pkt=%h, want %b/0", rx_we4, dest_err4, rx_pkt4, exp_we);
        end
        tick();
        n_checks++;
        if (rx_we4 !== 4'b0000 || tx_ready4 !== 4'b1111) begin
            n_fail++;
            $display("FAIL broadcast_after: rx_we=%b tx_ready=%b, want 0000/1111", rx_we4, tx_ready4);
        end
    endtask

    initial begin
        rst       = 1'b1;
        tx_valid4 = '0;
        tx_valid3 = '0;
        tx_pkt4   = '0;
        tx_pkt3   = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_bad_dest();
        test_reset_midflight();
        test_broadcast();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
